// File: rtl/free_reg_release_queue_pkg.sv
// rtl/free_reg_release_queue_pkg.sv - shared tag/lane types and mask helpers for the free list slice
package free_reg_release_queue_pkg;

  localparam int N_PHYS_REGS = 64;
  localparam int TAG_WIDTH   = $clog2(N_PHYS_REGS);
  localparam int WIDTH       = 4;

  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef logic [0:WIDTH-1]     lane_mask_t;

  function automatic logic [2:0] popcount4(input lane_mask_t m);
    return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
  endfunction

  // Lanes 0..n-1 set, bit 0 first.
  function automatic lane_mask_t contiguous_mask(input logic [2:0] n);
    lane_mask_t r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (3'(i) < n) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/free_reg_release_queue_if.sv
// rtl/free_reg_release_queue_if.sv - commit-side and free-list put-side signals of the release queue
interface free_reg_release_queue_if
  import free_reg_release_queue_pkg::*;
#(
  parameter int DEPTH = 16
);

  logic                     commitEn;
  lane_mask_t               commitHasDest;
  tag_t                     commitTag0;
  tag_t                     commitTag1;
  tag_t                     commitTag2;
  tag_t                     commitTag3;
  logic                     hold;
  logic                     commitAllow;
  lane_mask_t               put;
  logic                     enablePut;
  tag_t                     writePut0;
  tag_t                     writePut1;
  tag_t                     writePut2;
  tag_t                     writePut3;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport slave (
    input  commitEn, commitHasDest, commitTag0, commitTag1, commitTag2, commitTag3, hold,
    output commitAllow, put, enablePut, writePut0, writePut1, writePut2, writePut3,
           count, overflow
  );

  modport master (
    output commitEn, commitHasDest, commitTag0, commitTag1, commitTag2, commitTag3, hold,
    input  commitAllow, put, enablePut, writePut0, writePut1, writePut2, writePut3,
           count, overflow
  );

endinterface

// File: rtl/free_reg_release_queue_tag_compactor4.sv
// rtl/free_reg_release_queue_tag_compactor4.sv - packs the released tags of a commit group, lane order kept
module tag_compactor4
  import free_reg_release_queue_pkg::*;
(
  input  lane_mask_t mask,
  input  tag_t       tagsIn  [WIDTH],
  output logic [2:0] nIn,
  output tag_t       tagsOut [WIDTH]
);

  logic [2:0] slot;

  assign nIn = popcount4(mask);

  always_comb begin
    tagsOut = '{default: '0};
    slot    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) begin
        tagsOut[slot[1:0]] = tagsIn[i];
        slot               = slot + 3'd1;
      end
    end
  end

endmodule

// File: rtl/free_reg_release_queue.sv
// rtl/free_reg_release_queue.sv - buffers released tags at commit and drains compacted groups to the free list
module free_reg_release_queue
  import free_reg_release_queue_pkg::*;
#(
  parameter int DEPTH = 16
)(
  input logic                      clk,
  input logic                      reset,
  free_reg_release_queue_if.slave  q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  tag_t             mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             overflow;

  tag_t             inTags     [WIDTH];
  tag_t             packedTags [WIDTH];
  tag_t             outTags    [WIDTH];
  logic [2:0]       nIn;
  logic [CNT_W-1:0] freeSlots;
  logic [CNT_W-1:0] nWr;
  logic [CNT_W-1:0] nOut;
  logic             allow;
  logic             drain;

  assign inTags[0] = q.commitTag0;
  assign inTags[1] = q.commitTag1;
  assign inTags[2] = q.commitTag2;
  assign inTags[3] = q.commitTag3;

  tag_compactor4 u_compactor (
    .mask    (q.commitHasDest),
    .tagsIn  (inTags),
    .nIn     (nIn),
    .tagsOut (packedTags)
  );

  // Free space is taken from the registered count, so slots drained this cycle are not reused.
  always_comb begin
    freeSlots = CNT_W'(DEPTH) - count;
    allow     = freeSlots >= CNT_W'(WIDTH);
    nWr       = '0;
    if (q.commitEn) begin
      nWr = (CNT_W'(nIn) > freeSlots) ? freeSlots : CNT_W'(nIn);
    end
    nOut  = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;
    drain = (count != '0) && !q.hold;
  end

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      outTags[k] = (CNT_W'(k) < nOut) ? mem[head + PTR_W'(k)] : '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < WIDTH; k++) begin
      if (CNT_W'(k) < nWr) mem[tail + PTR_W'(k)] <= packedTags[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      tail  <= tail + nWr[PTR_W-1:0];
      count <= count + nWr - (drain ? nOut : '0);
      if (drain) head <= head + nOut[PTR_W-1:0];
      if (q.commitEn && !allow) overflow <= 1'b1;
    end
  end

  assign q.commitAllow = allow;
  assign q.put         = contiguous_mask(nOut[2:0]);
  assign q.enablePut   = drain;
  assign q.writePut0   = outTags[0];
  assign q.writePut1   = outTags[1];
  assign q.writePut2   = outTags[2];
  assign q.writePut3   = outTags[3];
  assign q.count       = count;
  assign q.overflow    = overflow;

endmodule

// File: tb/tb_free_reg_release_queue.sv
// tb/tb_free_reg_release_queue.sv - scoreboard bench for the free register release queue
module tb_free_reg_release_queue;
  import free_reg_release_queue_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  free_reg_release_queue_if #(.DEPTH(16)) q();

  free_reg_release_queue #(.DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q.slave)
  );

  typedef struct {
    int put;
    int t[4];
  } grp_t;

  grp_t sb[$];
  int   pend[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Split pending tags into drain groups of up to four, oldest first.
  task automatic flush_groups();
    int masks[5] = '{0, 8, 12, 14, 15};
    grp_t g;
    int n;
    while (pend.size() > 0) begin
      n = 0;
      g.t = '{0, 0, 0, 0};
      while (n < 4 && pend.size() > 0) begin
        g.t[n] = pend.pop_front();
        n++;
      end
      g.put = masks[n];
      sb.push_back(g);
    end
  endtask

  task automatic enq(input logic [0:3] m, input int t0, input int t1, input int t2, input int t3);
    q.commitEn      = 1'b1;
    q.commitHasDest = m;
    q.commitTag0    = tag_t'(t0);
    q.commitTag1    = tag_t'(t1);
    q.commitTag2    = tag_t'(t2);
    q.commitTag3    = tag_t'(t3);
    tick();
    q.commitEn      = 1'b0;
    q.commitHasDest = '0;
  endtask

  initial begin : monitor
    grp_t g;
    forever begin
      @(negedge clk);
      if (reset && q.enablePut) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_drain: put=%b w0=%0d expected no group", q.put, q.writePut0);
        end else begin
          g = sb.pop_front();
          chk("drain_put", int'(q.put), g.put);
          chk("drain_w0", int'(q.writePut0), g.t[0]);
          chk("drain_w1", int'(q.writePut1), g.t[1]);
          chk("drain_w2", int'(q.writePut2), g.t[2]);
          chk("drain_w3", int'(q.writePut3), g.t[3]);
        end
      end
    end
  end

  initial begin : stimulus
    q.commitEn      = 1'b0;
    q.commitHasDest = '0;
    q.commitTag0    = '0;
    q.commitTag1    = '0;
    q.commitTag2    = '0;
    q.commitTag3    = '0;
    q.hold          = 1'b0;

    // reset
    #2 reset = 1'b0;
    tick();
    tick();
    chk("rst_count", int'(q.count), 0);
    chk("rst_enablePut", int'(q.enablePut), 0);
    chk("rst_put", int'(q.put), 0);
    chk("rst_commitAllow", int'(q.commitAllow), 1);
    chk("rst_overflow", int'(q.overflow), 0);
    reset = 1'b1;
    tick();

    // compaction of a sparse mask
    pend.push_back(40); pend.push_back(42); pend.push_back(43);
    flush_groups();
    enq(4'b1011, 40, 41, 42, 43);
    chk("cmp_count", int'(q.count), 3);
    chk("cmp_enablePut", int'(q.enablePut), 1);
    tick();
    chk("cmp_count_after", int'(q.count), 0);
    chk("cmp_enable_after", int'(q.enablePut), 0);
    enq(4'b0000, 1, 2, 3, 4);
    chk("empty_mask_count", int'(q.count), 0);

    // fill to full under hold, then drain in order
    q.hold = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) pend.push_back(32 + 4 * c + k);
      enq(4'b1111, 32 + 4 * c, 33 + 4 * c, 34 + 4 * c, 35 + 4 * c);
      chk("full_count", int'(q.count), 4 * (c + 1));
      chk("full_commitAllow", int'(q.commitAllow), (c < 3) ? 1 : 0);
    end
    chk("hold_enablePut", int'(q.enablePut), 0);
    flush_groups();
    q.hold = 1'b0;
    repeat (4) tick();
    chk("full_drained", int'(q.count), 0);

    // advance head/tail to 12, stage two tags, then wrap while draining
    q.hold = 1'b1;
    for (int k = 1; k <= 9; k++) pend.push_back(k);
    flush_groups();
    enq(4'b1111, 1, 2, 3, 4);
    enq(4'b1111, 5, 6, 7, 8);
    enq(4'b1000, 9, 0, 0, 0);
    chk("adv_count", int'(q.count), 9);
    q.hold = 1'b0;
    repeat (3) tick();
    chk("adv_drained", int'(q.count), 0);
    q.hold = 1'b1;
    pend.push_back(48); pend.push_back(49);
    flush_groups();
    enq(4'b1100, 48, 49, 0, 0);
    chk("wrap_pre_count", int'(q.count), 2);
    for (int k = 50; k <= 53; k++) pend.push_back(k);
    flush_groups();
    q.hold = 1'b0;
    enq(4'b1111, 50, 51, 52, 53);
    chk("wrap_sim_count", int'(q.count), 4);
    chk("wrap_enablePut", int'(q.enablePut), 1);
    tick();
    chk("wrap_drained", int'(q.count), 0);

    // overflow: only two lanes fit at count 14
    q.hold = 1'b1;
    enq(4'b1111, 10, 11, 12, 13);
    enq(4'b1111, 14, 15, 16, 17);
    enq(4'b1111, 18, 19, 20, 21);
    enq(4'b1100, 22, 23, 0, 0);
    chk("ovf_pre_count", int'(q.count), 14);
    chk("ovf_pre_allow", int'(q.commitAllow), 0);
    chk("ovf_pre_flag", int'(q.overflow), 0);
    enq(4'b1111, 60, 61, 62, 63);
    chk("ovf_count", int'(q.count), 16);
    chk("ovf_flag", int'(q.overflow), 1);
    tick();
    chk("ovf_sticky", int'(q.overflow), 1);
    for (int k = 10; k <= 23; k++) pend.push_back(k);
    pend.push_back(60); pend.push_back(61);
    flush_groups();
    q.hold = 1'b0;
    repeat (4) tick();
    chk("ovf_drained", int'(q.count), 0);
    chk("ovf_sticky_end", int'(q.overflow), 1);

    // async reset while a group is on offer
    q.hold = 1'b1;
    enq(4'b1111, 24, 25, 26, 27);
    enq(4'b1111, 28, 29, 30, 31);
    enq(4'b1000, 32, 0, 0, 0);
    chk("mid_count", int'(q.count), 9);
    #1 q.hold = 1'b0;
    #1 chk("mid_enablePut", int'(q.enablePut), 1);
    #1 reset = 1'b0;
    sb.delete();
    #1;
    chk("arst_count", int'(q.count), 0);
    chk("arst_enablePut", int'(q.enablePut), 0);
    chk("arst_put", int'(q.put), 0);
    chk("arst_w0", int'(q.writePut0), 0);
    chk("arst_commitAllow", int'(q.commitAllow), 1);
    chk("arst_overflow", int'(q.overflow), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_count", int'(q.count), 0);
    chk("post_rst_enablePut", int'(q.enablePut), 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
